// File: rtl/alu_pipe_acc.sv
// Registered ALU with valid/ready handshake, status flags, accumulator
// feedback, optional saturating add/sub and an accepted-beat counter.
module alu_pipe_acc #(
   parameter int W     = 8,
   parameter int SAT   = 0,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [2:0]       op,
   input  logic             acc_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out,
   output logic [3:0]       flags,
   output logic [W-1:0]     acc,
   output logic [CNT_W-1:0] op_count
);

   localparam int SH_W = $clog2(W);

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_NOT = 3'd5,
      OP_SHL = 3'd6,
      OP_SHR = 3'd7
   } op_e;

   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     out_q, out_d;
   logic [3:0]       flags_q, flags_d;
   logic [W-1:0]     acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             accept;
   logic [W-1:0]     opa, res;
   logic             res_c, res_v;
   logic [W:0]       sum, diff, shl;
   logic [W:0]       shr;
   logic [SH_W-1:0]  shamt;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Operand A comes from the registered accumulator, so chained beats see
   // the previous result without any forwarding logic.
   assign opa   = acc_sel ? acc_q : a;
   assign shamt = b[SH_W-1:0];
   assign sum   = {1'b0, opa} + {1'b0, b};
   assign diff  = {1'b0, opa} - {1'b0, b};
   // Extra bit above (SHL) or below (SHR) the operand catches the last bit shifted out.
   assign shl   = {1'b0, opa} << shamt;
   assign shr   = {opa, 1'b0} >> shamt;

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case statement can leave a latch behind.
   always_comb begin
      res   = '0;
      res_c = 1'b0;
      res_v = 1'b0;
      case (op_e'(op))
         OP_ADD: begin
            res   = sum[W-1:0];
            res_c = sum[W];
            res_v = (opa[W-1] == b[W-1]) && (sum[W-1] != opa[W-1]);
            if (SAT != 0 && sum[W]) res = '1;
         end
         OP_SUB: begin
            res   = diff[W-1:0];
            res_c = diff[W];
            res_v = (opa[W-1] != b[W-1]) && (diff[W-1] != opa[W-1]);
            if (SAT != 0 && diff[W]) res = '0;
         end
         OP_AND: res = opa & b;
         OP_OR:  res = opa | b;
         OP_XOR: res = opa ^ b;
         OP_NOT: res = ~opa;
         OP_SHL: begin
            res   = shl[W-1:0];
            res_c = shl[W];
         end
         OP_SHR: begin
            res   = shr[W:1];
            res_c = shr[0];
         end
         default: res = '0;
      endcase
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_d       = out_q;
      flags_d     = flags_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_d       = res;
         flags_d     = {res[W-1], res_v, res_c, (res == '0)};
         acc_d       = res;
         cnt_d       = cnt_q + 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
         flags_q     <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         flags_q     <= flags_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign flags     = flags_q;
   assign acc       = acc_q;
   assign op_count  = cnt_q;

endmodule
